// File: rtl/raptor64_dcache_pkg.sv
// Raptor64 dcache data-array shared types and width helpers.
package raptor64_dcache_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        DONE
    } fill_state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << i) < v) r = i + 1;
        return r;
    endfunction

    function automatic int lanes_f(input int rd_w, input int fill_w);
        return rd_w / fill_w;
    endfunction

    function automatic int beats_f(input int line_words, input int rd_w,
                                   input int fill_w);
        return line_words * (rd_w / fill_w);
    endfunction

    // beat counter never collapses to zero width for single-beat lines
    function automatic int cnt_w_f(input int beats);
        return (clog2(beats) < 1) ? 1 : clog2(beats);
    endfunction

endpackage

// File: rtl/raptor64_dcache_dataram_if.sv
// Fill, store and read bus of the Raptor64 dcache data array.
interface raptor64_dcache_dataram_if
    import raptor64_dcache_pkg::*;
#(
    parameter int DEPTH_LOG2 = 11,
    parameter int RD_W       = 64,
    parameter int FILL_W     = 32,
    parameter int LINE_WORDS = 4
);
    localparam int LINE_AW = DEPTH_LOG2 - clog2(LINE_WORDS);

    logic                  fill_start;
    logic [LINE_AW-1:0]    fill_line;
    logic                  fill_valid;
    logic [FILL_W-1:0]     fill_data;
    logic                  fill_ready;
    logic                  fill_busy;
    logic                  fill_done;
    logic                  st_wr;
    logic                  st_ready;
    logic [RD_W/8-1:0]     st_sel;
    logic [DEPTH_LOG2-1:0] st_adr;
    logic [RD_W-1:0]       st_data;
    logic                  rd_en;
    logic [DEPTH_LOG2-1:0] rd_adr;
    logic [RD_W-1:0]       rd_data;
    logic                  rd_valid;

    modport master (
        output fill_start, fill_line, fill_valid, fill_data,
        output st_wr, st_sel, st_adr, st_data, rd_en, rd_adr,
        input  fill_ready, fill_busy, fill_done, st_ready,
        input  rd_data, rd_valid
    );

    modport slave (
        input  fill_start, fill_line, fill_valid, fill_data,
        input  st_wr, st_sel, st_adr, st_data, rd_en, rd_adr,
        output fill_ready, fill_busy, fill_done, st_ready,
        output rd_data, rd_valid
    );

endinterface

// File: rtl/raptor64_dcache_bank.sv
// Simple dual-port RAM: one byte-enabled write port, one asynchronous read port.
module raptor64_dcache_bank #(
    parameter int AW = 11,
    parameter int DW = 64
) (
    input  logic          clk,
    input  logic [DW/8-1:0] we,
    input  logic [AW-1:0] wadr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] radr,
    output logic [DW-1:0] rdata
);
    logic [DW-1:0] mem [0:(1<<AW)-1];

    always_ff @(posedge clk) begin
        for (int b = 0; b < DW / 8; b++)
            if (we[b]) mem[wadr][b*8 +: 8] <= wdata[b*8 +: 8];
    end

    assign rdata = mem[radr];

endmodule

// File: rtl/raptor64_dcache_dataram.sv
// Raptor64 dcache data array: store port, registered read, line-fill sequencer.
// Define DCACHE_WR_BYPASS_EN to forward same-cycle writes into colliding reads.
module raptor64_dcache_dataram
    import raptor64_dcache_pkg::*;
#(
    parameter int DEPTH_LOG2 = 11,
    parameter int RD_W       = 64,
    parameter int FILL_W     = 32,
    parameter int LINE_WORDS = 4
) (
    input logic clk,
    input logic rst_n,
    raptor64_dcache_dataram_if.slave bus
);
    localparam int LANES     = lanes_f(RD_W, FILL_W);
    localparam int BEATS     = beats_f(LINE_WORDS, RD_W, FILL_W);
    localparam int CNT_W     = cnt_w_f(BEATS);
    localparam int LANE_BITS = clog2(LANES);
    localparam int LW_BITS   = clog2(LINE_WORDS);
    localparam int LINE_AW   = DEPTH_LOG2 - LW_BITS;
    localparam int BE_W      = RD_W / 8;
    localparam int FB_W      = FILL_W / 8;

    fill_state_t           state, state_nx;
    logic [CNT_W-1:0]      cnt, cnt_nx;
    logic [LINE_AW-1:0]    line_q, line_nx;
    logic                  fill_ready, fill_busy, fill_done, st_ready;
    logic                  fill_acc, st_acc;
    logic [DEPTH_LOG2-1:0] fill_adr, wadr;
    logic [BE_W-1:0]       we;
    logic [RD_W-1:0]       wdata, ram_q, rd_word, rd_q;
    logic                  rd_v_q;
    int                    lane;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            line_q <= '0;
        end else begin
            state  <= state_nx;
            cnt    <= cnt_nx;
            line_q <= line_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        line_nx    = line_q;
        fill_ready = 1'b0;
        fill_busy  = 1'b0;
        fill_done  = 1'b0;
        st_ready   = 1'b0;
        unique case (state)
            IDLE: begin
                st_ready = 1'b1;
                if (bus.fill_start) begin
                    state_nx = FILL;
                    line_nx  = bus.fill_line;
                    cnt_nx   = '0;
                end
            end
            FILL: begin
                fill_ready = 1'b1;
                fill_busy  = 1'b1;
                if (bus.fill_valid) begin
                    if (cnt == CNT_W'(BEATS - 1)) begin
                        state_nx = DONE;
                        cnt_nx   = '0;
                    end else begin
                        cnt_nx = cnt + 1'b1;
                    end
                end
            end
            DONE: begin
                fill_busy = 1'b1;
                fill_done = 1'b1;
                state_nx  = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // fill and store never overlap: stores only in IDLE, beats only in FILL
    always_comb begin
        fill_acc = fill_ready & bus.fill_valid;
        st_acc   = st_ready & bus.st_wr;
        lane     = int'(cnt) % LANES;
        fill_adr = (DEPTH_LOG2'(line_q) << LW_BITS)
                 | DEPTH_LOG2'(cnt >> LANE_BITS);
        we       = '0;
        wadr     = bus.st_adr;
        wdata    = bus.st_data;
        if (fill_acc) begin
            wadr  = fill_adr;
            wdata = {LANES{bus.fill_data}};
            for (int b = 0; b < BE_W; b++)
                we[b] = ((b / FB_W) == lane);
        end else if (st_acc) begin
            we = bus.st_sel;
        end
    end

    raptor64_dcache_bank #(
        .AW(DEPTH_LOG2),
        .DW(RD_W)
    ) u_bank (
        .clk  (clk),
        .we   (we),
        .wadr (wadr),
        .wdata(wdata),
        .radr (bus.rd_adr),
        .rdata(ram_q)
    );

`ifdef DCACHE_WR_BYPASS_EN
    always_comb begin
        rd_word = ram_q;
        if (wadr == bus.rd_adr)
            for (int b = 0; b < BE_W; b++)
                if (we[b]) rd_word[b*8 +: 8] = wdata[b*8 +: 8];
    end
`else
    assign rd_word = ram_q;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_q   <= '0;
            rd_v_q <= 1'b0;
        end else begin
            rd_v_q <= bus.rd_en;
            if (bus.rd_en) rd_q <= rd_word;
        end
    end

    assign bus.fill_ready = fill_ready;
    assign bus.fill_busy  = fill_busy;
    assign bus.fill_done  = fill_done;
    assign bus.st_ready   = st_ready;
    assign bus.rd_data    = rd_q;
    assign bus.rd_valid   = rd_v_q;

endmodule
